// File: rtl/video_pattern_stream_if.sv
// Video pattern stream bundle: start/config controls into the source,
// raster timing, pixel data and frame status out of it.
// master = the pattern source, slave = the consumer/controller side.
interface video_pattern_stream_if #(
   parameter int CH = 3,
   parameter int DW = 8
) ();
   logic                vout_begin;
   logic                vout_cont;
   logic [2:0]          cfg_mode;
   logic [CH*DW-1:0]    cfg_color;
   logic                vout_vsync;
   logic                vout_hsync;
   logic                vout_valid;
   logic [CH*DW-1:0]    vout_dat;
   logic                vout_sof;
   logic                vout_eol;
   logic                vout_busy;
   logic                vout_done;
   logic [15:0]         vout_frame_cnt;
   logic [15:0]         vout_xres;
   logic [15:0]         vout_yres;

   modport master (
      input  vout_begin, vout_cont, cfg_mode, cfg_color,
      output vout_vsync, vout_hsync, vout_valid, vout_dat, vout_sof, vout_eol,
             vout_busy, vout_done, vout_frame_cnt, vout_xres, vout_yres
   );

   modport slave (
      output vout_begin, vout_cont, cfg_mode, cfg_color,
      input  vout_vsync, vout_hsync, vout_valid, vout_dat, vout_sof, vout_eol,
             vout_busy, vout_done, vout_frame_cnt, vout_xres, vout_yres
   );
endinterface

// File: rtl/video_pattern_stream.sv
// Raster timing generator with selectable test patterns (solid, ramps,
// colour bars, checker, moving ramp). Single-shot or back-to-back frames.
// Optional macro VIDEO_PATTERN_STREAM_BORDER_EN forces a one-pixel all-ones
// border around the active area.
module video_pattern_stream #(
   parameter int H_SYNC   = 40,
   parameter int H_BACK   = 220,
   parameter int H_DISP   = 1280,
   parameter int H_FRONT  = 110,
   parameter int V_SYNC   = 5,
   parameter int V_BACK   = 20,
   parameter int V_DISP   = 720,
   parameter int V_FRONT  = 5,
   parameter int CH       = 3,
   parameter int DW       = 8,
   parameter int CHK_LOG2 = 4
) (
   input logic                     clk,
   input logic                     rst,
   video_pattern_stream_if.master  vout
);

   if (CH < 1 || DW < 1 || H_DISP < 8) begin : g_bad_param
      $error("video_pattern_stream: requires CH>=1, DW>=1, H_DISP>=8");
   end

   localparam logic [15:0] HTotal = 16'(H_SYNC + H_BACK + H_DISP + H_FRONT);
   localparam logic [15:0] VTotal = 16'(V_SYNC + V_BACK + V_DISP + V_FRONT);
   localparam logic [15:0] HSync  = 16'(H_SYNC);
   localparam logic [15:0] VSync  = 16'(V_SYNC);
   localparam logic [15:0] HAct0  = 16'(H_SYNC + H_BACK);
   localparam logic [15:0] HAct1  = 16'(H_SYNC + H_BACK + H_DISP);
   localparam logic [15:0] VAct0  = 16'(V_SYNC + V_BACK);
   localparam logic [15:0] VAct1  = 16'(V_SYNC + V_BACK + V_DISP);
   localparam logic [15:0] XLast  = 16'(H_DISP - 1);
   localparam logic [15:0] BarW   = 16'(H_DISP / 8);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic             begin_d_q;
   logic [15:0]      h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic [2:0]       mode_q;
   logic [CH*DW-1:0] color_q;

   logic             start, run, line_end, frame_end, active;
   logic [15:0]      x, y, bar_raw;
   logic [2:0]       bar, bar_inv;
   logic [CH*DW-1:0] pix;

   logic             vsync_q, hsync_q, valid_q, sof_q, eol_q, done_q;
   logic [CH*DW-1:0] dat_q;

   // begin_d resets to 0, so a begin held through reset starts a frame
   assign start     = vout.vout_begin & ~begin_d_q;
   assign run       = (state_q == StRun);
   assign line_end  = run && (h_cnt_q == HTotal - 16'd1);
   assign frame_end = line_end && (v_cnt_q == VTotal - 16'd1);
   assign active    = run && (h_cnt_q >= HAct0) && (h_cnt_q < HAct1) &&
                      (v_cnt_q >= VAct0) && (v_cnt_q < VAct1);
   assign x         = h_cnt_q - HAct0;
   assign y         = v_cnt_q - VAct0;

   // Next-state: raster counters, frame counter, idle/run control
   always_comb begin
      state_d     = state_q;
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               h_cnt_d = '0;
               v_cnt_d = '0;
            end
         end
         StRun: begin
            if (frame_end) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               h_cnt_d     = '0;
               v_cnt_d     = '0;
               if (!vout.vout_cont) state_d = StIdle;
            end else if (line_end) begin
               h_cnt_d = '0;
               v_cnt_d = v_cnt_q + 16'd1;
            end else begin
               h_cnt_d = h_cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, counters, edge detector and per-frame config shadow registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         begin_d_q   <= 1'b0;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         frame_cnt_q <= '0;
         mode_q      <= '0;
         color_q     <= '0;
      end else begin
         state_q     <= state_d;
         begin_d_q   <= vout.vout_begin;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         // (0,0) is never active, so new config never tears a frame
         if (run && h_cnt_q == 16'd0 && v_cnt_q == 16'd0) begin
            mode_q  <= vout.cfg_mode;
            color_q <= vout.cfg_color;
         end
      end
   end

   // Pattern pixel for the current counter position
   always_comb begin
      pix     = '0;
      bar_raw = x / BarW;
      bar     = (bar_raw > 16'd7) ? 3'd7 : bar_raw[2:0];
      bar_inv = 3'd7 - bar;
      case (mode_q)
         3'd0: pix = color_q;
         3'd1: for (int c = 0; c < CH; c++) pix[c*DW +: DW] = DW'(x);
         3'd2: for (int c = 0; c < CH; c++) pix[c*DW +: DW] = DW'(y);
         3'd3: begin
            // bar 0 = white, bar 7 = black; channel c follows bit c%3
            for (int c = 0; c < CH; c++) begin
               pix[c*DW +: DW] = (((bar_inv >> (c % 3)) & 3'd1) != 3'd0) ? {DW{1'b1}} : '0;
            end
         end
         3'd4: pix = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? '1 : '0;
         3'd5: for (int c = 0; c < CH; c++) pix[c*DW +: DW] = DW'(x + frame_cnt_q);
         default: pix = '0;
      endcase
`ifdef VIDEO_PATTERN_STREAM_BORDER_EN
      if (x == 16'd0 || x == XLast || y == 16'd0 || y == 16'(V_DISP - 1)) pix = '1;
`else
`endif
   end

   // Output register stage: everything reflects counters one cycle late
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_q <= 1'b0;
         hsync_q <= 1'b0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         done_q  <= 1'b0;
         dat_q   <= '0;
      end else begin
         vsync_q <= run && (v_cnt_q < VSync);
         hsync_q <= run && (h_cnt_q < HSync);
         valid_q <= active;
         sof_q   <= active && (x == 16'd0) && (y == 16'd0);
         eol_q   <= active && (x == XLast);
         done_q  <= frame_end;
         dat_q   <= active ? pix : '0;
      end
   end

   assign vout.vout_vsync     = vsync_q;
   assign vout.vout_hsync     = hsync_q;
   assign vout.vout_valid     = valid_q;
   assign vout.vout_dat       = dat_q;
   assign vout.vout_sof       = sof_q;
   assign vout.vout_eol       = eol_q;
   assign vout.vout_busy      = run;
   assign vout.vout_done      = done_q;
   // Incremented on the frame-end edge, so it lines up with done
   assign vout.vout_frame_cnt = frame_cnt_q;
   assign vout.vout_xres      = 16'(H_DISP);
   assign vout.vout_yres      = 16'(V_DISP);

endmodule

// File: tb/tb_video_pattern_stream.sv
// Bench for video_pattern_stream in a small raster (24x12 total, 16x8 active).
// The reference walks a linear position through the frame and derives every
// output from x/y arithmetic on that position.
module tb_video_pattern_stream;

   localparam int HS = 2, HB = 3, HD = 16, HF = 3;
   localparam int VS = 1, VB = 2, VD = 8, VF = 1;
   localparam int HT = HS + HB + HD + HF;
   localparam int VT = VS + VB + VD + VF;
   localparam int FT = HT * VT;
   localparam int CHK = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   video_pattern_stream_if #(.CH(3), .DW(8)) vif ();

   video_pattern_stream #(
      .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
      .CH(3), .DW(8), .CHK_LOG2(CHK)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .vout (vif)
   );

   int checks = 0;
   int errors = 0;
   int n_valid = 0;
   int n_done = 0;

   // reference model state
   bit          m_run;
   int          m_pos;
   logic [15:0] m_fcnt;
   bit          m_prev;
   int          m_mode;
   logic [23:0] m_color;
   logic        e_vsync, e_hsync, e_valid, e_sof, e_eol, e_busy, e_done;
   logic [23:0] e_dat;
   logic [15:0] e_fcnt;

   function automatic logic [23:0] ref_pix(int mode, int x, int y, int f, logic [23:0] color);
      logic [23:0] p;
      logic [7:0]  v;
      int          b;
      p = '0;
      case (mode)
         0: p = color;
         1: begin v = 8'(x % 256); p = {3{v}}; end
         2: begin v = 8'(y % 256); p = {3{v}}; end
         3: begin
            b = x / (HD / 8);
            if (b > 7) b = 7;
            for (int c = 0; c < 3; c++) p[c*8 +: 8] = (((7 - b) >> (c % 3)) & 1) != 0 ? 8'hFF : 8'h00;
         end
         4: p = ((((x >> CHK) & 1) ^ ((y >> CHK) & 1)) != 0) ? 24'hFFFFFF : 24'h0;
         5: begin v = 8'((x + f) % 256); p = {3{v}}; end
         default: p = '0;
      endcase
`ifdef VIDEO_PATTERN_STREAM_BORDER_EN
      if (x == 0 || x == HD - 1 || y == 0 || y == VD - 1) p = 24'hFFFFFF;
`else
`endif
      return p;
   endfunction

   task automatic model_reset();
      m_run = 0; m_pos = 0; m_fcnt = '0; m_prev = 0; m_mode = 0; m_color = '0;
      e_vsync = 0; e_hsync = 0; e_valid = 0; e_sof = 0; e_eol = 0;
      e_busy = 0; e_done = 0; e_dat = '0; e_fcnt = '0;
   endtask

   // Predict outputs after the coming clock edge from the inputs now applied
   task automatic model_eval();
      int col, line, x, y;
      bit act;
      if (rst) begin
         model_reset();
         return;
      end
      col  = m_pos % HT;
      line = m_pos / HT;
      x    = col - (HS + HB);
      y    = line - (VS + VB);
      if (m_run && m_pos == 0) begin
         m_mode  = int'(vif.cfg_mode);
         m_color = vif.cfg_color;
      end
      act     = m_run && x >= 0 && x < HD && y >= 0 && y < VD;
      e_hsync = m_run && col < HS;
      e_vsync = m_run && line < VS;
      e_valid = act;
      e_dat   = act ? ref_pix(m_mode, x, y, int'(m_fcnt), m_color) : 24'h0;
      e_sof   = act && x == 0 && y == 0;
      e_eol   = act && x == HD - 1;
      e_done  = m_run && m_pos == FT - 1;
      if (m_run) begin
         if (m_pos == FT - 1) begin
            m_fcnt = m_fcnt + 16'd1;
            m_pos  = 0;
            m_run  = vif.vout_cont;
         end else begin
            m_pos++;
         end
      end else if (vif.vout_begin && !m_prev) begin
         m_run = 1;
         m_pos = 0;
      end
      m_prev = vif.vout_begin;
      e_busy = m_run;
      e_fcnt = m_fcnt;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   task automatic check_all();
      chk("vsync", 32'(vif.vout_vsync), 32'(e_vsync));
      chk("hsync", 32'(vif.vout_hsync), 32'(e_hsync));
      chk("valid", 32'(vif.vout_valid), 32'(e_valid));
      chk("dat", 32'(vif.vout_dat), 32'(e_dat));
      chk("sof", 32'(vif.vout_sof), 32'(e_sof));
      chk("eol", 32'(vif.vout_eol), 32'(e_eol));
      chk("busy", 32'(vif.vout_busy), 32'(e_busy));
      chk("done", 32'(vif.vout_done), 32'(e_done));
      chk("frame_cnt", 32'(vif.vout_frame_cnt), 32'(e_fcnt));
      chk("xres", 32'(vif.vout_xres), 32'd16);
      chk("yres", 32'(vif.vout_yres), 32'd8);
      if (vif.vout_valid === 1'b1) n_valid++;
      if (vif.vout_done === 1'b1) n_done++;
   endtask

   // One clock: predict, let the edge happen, compare on the falling edge
   task automatic cycle(input int n);
      for (int i = 0; i < n; i++) begin
         model_eval();
         @(posedge clk);
         @(negedge clk);
         check_all();
      end
   endtask

   initial begin
      vif.vout_begin = 1'b0;
      vif.vout_cont  = 1'b0;
      vif.cfg_mode   = 3'd1;
      vif.cfg_color  = 24'h0;
      model_reset();

      // reset state
      @(negedge clk);
      check_all();
      cycle(2);
      rst = 1'b0;
      cycle(3);

      // single frame, horizontal ramp
      n_valid = 0;
      n_done  = 0;
      vif.vout_begin = 1'b1;
      cycle(FT + 10);
      chk("frame1_valid_count", 32'(n_valid), 32'd128);
      chk("frame1_done_count", 32'(n_done), 32'd1);
      chk("frame1_idle", 32'(vif.vout_busy), 32'd0);
      vif.vout_begin = 1'b0;
      cycle(2);

      // back-to-back colour bars
      vif.vout_cont = 1'b1;
      vif.cfg_mode  = 3'd3;
      vif.vout_begin = 1'b1;
      cycle(2 * FT + 5);
      vif.vout_begin = 1'b0;

      // solid colour, then switch to checker mid-frame
      vif.cfg_mode  = 3'd0;
      vif.cfg_color = 24'h102030;
      cycle(FT);
      vif.cfg_mode  = 3'd4;
      cycle(FT + 20);

      // moving ramp across several frames
      vif.cfg_mode = 3'd5;
      cycle(3 * FT + 7);

      // random configuration, continuation and begin activity
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) vif.cfg_mode = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) vif.cfg_color = 24'($urandom);
         if ($urandom_range(0, 199) == 0) vif.vout_cont = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0) vif.vout_begin = 1'($urandom_range(0, 1));
         cycle(1);
      end
      vif.vout_cont  = 1'b0;
      vif.vout_begin = 1'b0;
      cycle(FT + 5);
      chk("drain_idle", 32'(vif.vout_busy), 32'd0);

      // reset 100 cycles into a frame
      vif.cfg_mode = 3'd2;
      vif.vout_begin = 1'b1;
      n_done = 0;
      cycle(100);
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("no_done_on_reset", 32'(n_done), 32'd0);
      @(negedge clk);
      cycle(2);
      rst = 1'b0;
      vif.vout_begin = 1'b0;
      cycle(3);
      vif.vout_begin = 1'b1;
      cycle(FT + 10);
      chk("restart_frame_cnt", 32'(vif.vout_frame_cnt), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/video_pattern_stream.md
Name: video_pattern_stream

Overview:
- Synthesizable, parametrised successor to the simulation-only BMP stream source.
- Generates raster timing (hsync/vsync/valid) plus selectable test-pattern pixel data for CH channels of DW bits each.
- Supports single-shot or continuous frames and a frame counter.
- Drives the CLAHE input path in FPGA bring-up and in full-chip simulation without file I/O.

Parameters:
- H_SYNC, 40: hsync width, clocks
- H_BACK, 220: horizontal back porch
- H_DISP, 1280: active pixels per line
- H_FRONT, 110: horizontal front porch
- V_SYNC, 5: vsync height, lines
- V_BACK, 20: vertical back porch
- V_DISP, 720: active lines
- V_FRONT, 5: vertical front porch
- CH, 3: channels per pixel
- DW, 8: bits per channel
- CHK_LOG2, 4: checkerboard square size is 2^CHK_LOG2 pixels

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- vout_begin  in  1  rising edge starts a frame when idle
- vout_cont  in  1  sampled at frame end; 1 = start next frame back-to-back
- cfg_mode  in  3  pattern select, latched at frame start
- cfg_color  in  CH*DW  solid colour, channel c at [c*DW +: DW], latched at frame start
- vout_vsync  out  1  high during the V_SYNC lines
- vout_hsync  out  1  high during the first H_SYNC clocks of each line
- vout_valid  out  1  active-pixel qualifier
- vout_dat  out  CH*DW  pixel data; 0 when vout_valid=0
- vout_sof  out  1  pulse with the first active pixel of a frame
- vout_eol  out  1  pulse with the last active pixel of each line
- vout_busy  out  1  frame in progress
- vout_done  out  1  one-cycle pulse, last cycle of each frame
- vout_frame_cnt  out  16  completed frames, wraps 0xFFFF->0
- vout_xres, vout_yres  out  16  constants H_DISP, V_DISP

Behaviour:
- Derived: H_TOTAL = sum of the four H parameters; V_TOTAL likewise.
- Elaboration error if CH<1, DW<1, or H_DISP<8.
- Reset values (async): all outputs 0, including begin_d, counters, latched mode/colour and frame_cnt.
- Start control:
  - Start pulse = vout_begin & ~begin_d.
  - Because begin_d resets to 0, a begin held high through reset starts a frame on the first clock after reset.
  - A start pulse while busy is ignored.
- FSM:
  - IDLE -> RUN on a start pulse. busy=1 the next cycle; h_cnt=v_cnt=0.
  - RUN: h_cnt counts 0..H_TOTAL-1 and wraps; v_cnt increments on each wrap.
  - At h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, frame end:
    - frame_cnt increments and done pulses.
    - If vout_cont=1, stay in RUN with counters reset to 0 (no idle gap).
    - Otherwise go to IDLE.
- Frame start: cfg_mode and cfg_color are latched into shadow registers whenever counters are (0,0) in RUN. Mid-frame cfg changes take effect only at the next frame.
- Output stage: one register stage. All timing and data outputs reflect counter state with 1-cycle latency; done and frame_cnt share the same alignment.
- Active region: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
  - x = h_cnt-(H_SYNC+H_BACK); y = v_cnt-(V_SYNC+V_BACK).
- Patterns (all channels unless noted; truncation keeps the low DW bits):
  - 0 solid: channel c = cfg_color[c].
  - 1 hramp: x.
  - 2 vramp: y.
  - 3 bars: bar index b = x/(H_DISP/8), saturating at 7. Channel c = all-ones if bit (c%3) of (7-b) is set, else 0. Bar 0 is white, bar 7 is black.
  - 4 checker: all-ones if x[CHK_LOG2]^y[CHK_LOG2], else 0.
  - 5 moving ramp: x + frame_cnt.
  - 6, 7: zero.
- Invalid or idle cycles: vout_dat=0, sof=0, eol=0.
- Mid-frame reset: immediate return to IDLE with all outputs 0. There is no partial-frame done.

Optional Feature:
- Macro: VIDEO_PATTERN_STREAM_BORDER_EN.
- Defined: pixels with x=0, x=H_DISP-1, y=0 or y=V_DISP-1 are forced to all-ones on every channel, overriding the pattern.
- Undefined: pattern output only; no border logic is compiled.

Test Plan:
Small configuration: H=2/3/16/3 (H_TOTAL 24), V=1/2/8/1 (V_TOTAL 12), CH=3, DW=8.
- Reset release, then a vout_begin 0->1 pulse, single frame, mode 1 -> exactly 8 lines of 16 valid pixels with dat 0..15. hsync high 2 clocks per line. vsync high for the first 24 output cycles. done once, 288 cycles after busy rises. frame_cnt=1. busy returns to 0.
- vout_cont=1, mode 3 -> back-to-back frames with no idle gap. Per line: pixels 0-1 = 0xFFFFFF, pixels 14-15 = 0x000000. frame_cnt increments every 288 cycles.
- Change cfg_mode 0->4 mid-frame with cfg_color=0x102030 -> current frame stays solid 0x102030. Next frame is checker with value flips at x=16 boundaries (16 = H_DISP, so none within a line) and y=16 (none).
- Mode 5 with continuous frames -> first pixel of frame n equals n mod 256.
- Assert rst at cycle 100 of a frame -> all outputs 0 asynchronously, no done. A begin pulse afterwards restarts at h=v=0.
- VIDEO_PATTERN_STREAM_BORDER_EN defined, mode 6 -> line 0 and line 7 are all 0xFFFFFF. Interior lines are 0xFFFFFF only at x=0 and x=15; all other pixels are 0.
